recovery_lock_monitor: RTL

Downstream consumer of the recovered primary-edge pulses produced by event recovery. Measures the sys-clock period between consecutive primary rising edges and tracks period stability against a tolerance. Declares lock after a run of consistent periods, and reports loss of lock on a period mismatch or a missing edge. Feeds clock-health status and the measured period to the clks_alot control/CSR layer.

---
 rtl/recovery_lock_monitor_pkg.sv | 21 ++
 rtl/recovery_lock_monitor_counter.sv | 30 +++
 rtl/recovery_lock_monitor.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/recovery_lock_monitor_pkg.sv
// Shared types for the recovered-clock lock monitor.
// Clock/reset bundle plus the lock state encoding seen by CSR logic.
package common_p;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;

endpackage

package clks_alot_p;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } lock_state_e;

endpackage

// File: rtl/recovery_lock_monitor_counter.sv
// Saturating sys-cycle counter cleared on each recovered edge.
// Exposes cnt+1 one bit wider so the period never wraps.
module edge_period_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_edge,
    output logic [COUNT_WIDTH:0]   o_cnt_p1,
    output logic                   o_sat
);

    logic [COUNT_WIDTH-1:0] r_cnt;

    assign o_sat    = &r_cnt;
    assign o_cnt_p1 = {1'b0, r_cnt} + (COUNT_WIDTH+1)'(1);

    // Restart on every edge or disable, otherwise count up and hold at all-ones
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || i_edge) begin
            r_cnt <= '0;
        end else if (!o_sat) begin
            r_cnt <= r_cnt + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/recovery_lock_monitor.sv
// Period measurement and lock tracking for recovered primary edges.
// Declares lock after a run of consistent periods, drops it on drift or loss.
module recovery_lock_monitor
    import common_p::*;
    import clks_alot_p::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int LOCK_COUNT  = 8,
    parameter int TOLERANCE   = 2
) (
    input  clk_dom_s               sys_dom_i,
    input  logic                   recovery_en_i,
    input  logic                   edge_event_i,
    output logic [COUNT_WIDTH-1:0] period_o,
    output logic                   period_valid_o,
    output logic                   locked_o,
    output logic                   lock_lost_o,
    output logic                   timeout_o,
    output logic [1:0]             state_o
);

    localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [COUNT_WIDTH:0] TOL  = (COUNT_WIDTH+1)'(TOLERANCE);
    localparam logic [MW-1:0]        LCNT = MW'(LOCK_COUNT);

    logic                   w_clk;
    logic                   w_rst_n;
    logic [COUNT_WIDTH:0]   w_cnt_p1;
    logic                   w_sat;
    logic [COUNT_WIDTH-1:0] w_period;
    logic [COUNT_WIDTH:0]   w_ref_ext;
    logic [COUNT_WIDTH:0]   w_diff;
    logic                   w_match;
    logic                   w_timeout;
    logic [MW-1:0]          w_match_nxt;

    lock_state_e            r_state;
    logic [COUNT_WIDTH-1:0] r_ref;
    logic                   r_ref_vld;
    logic [MW-1:0]          r_match_cnt;
    logic [COUNT_WIDTH-1:0] r_period;
    logic                   r_period_vld;
    logic                   r_locked;
    logic                   r_lock_lost;
    logic                   r_timeout;

    assign w_clk   = sys_dom_i.clk;
    assign w_rst_n = sys_dom_i.rst_n;

    edge_period_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_cnt (
        .i_clk    (w_clk),
        .i_rst_n  (w_rst_n),
        .i_clr    (!recovery_en_i),
        .i_edge   (edge_event_i),
        .o_cnt_p1 (w_cnt_p1),
        .o_sat    (w_sat)
    );

    // A period of 2^W cannot be reported, so it pins at all-ones
    assign w_period    = w_cnt_p1[COUNT_WIDTH] ? '1
                                               : w_cnt_p1[COUNT_WIDTH-1:0];
    assign w_ref_ext   = {1'b0, r_ref};
    assign w_diff      = (w_cnt_p1 >= w_ref_ext) ? (w_cnt_p1 - w_ref_ext)
                                                 : (w_ref_ext - w_cnt_p1);
    assign w_match     = (w_diff <= TOL);
    assign w_timeout   = !edge_event_i && r_ref_vld &&
                         ((w_cnt_p1 > {r_ref, 1'b0}) || w_sat);
    assign w_match_nxt = r_match_cnt + MW'(1);

    assign period_o       = r_period;
    assign period_valid_o = r_period_vld;
    assign locked_o       = r_locked;
    assign lock_lost_o    = r_lock_lost;
    assign timeout_o      = r_timeout;
    assign state_o        = r_state;

    // Lock FSM with tolerance tracking, match run length and status pulses
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= IDLE;
            r_ref        <= '0;
            r_ref_vld    <= 1'b0;
            r_match_cnt  <= '0;
            r_period     <= '0;
            r_period_vld <= 1'b0;
            r_locked     <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_period_vld <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_timeout    <= 1'b0;
            if (!recovery_en_i) begin
                r_state     <= IDLE;
                r_ref       <= '0;
                r_ref_vld   <= 1'b0;
                r_match_cnt <= '0;
                r_locked    <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (edge_event_i) begin
                            r_state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (edge_event_i) begin
                            r_period     <= w_period;
                            r_period_vld <= 1'b1;
                            r_ref        <= w_period;
                            r_ref_vld    <= 1'b1;
                            if (!r_ref_vld || !w_match) begin
                                r_match_cnt <= '0;
                            end else begin
                                r_match_cnt <= w_match_nxt;
                                if (w_match_nxt == LCNT) begin
                                    r_state  <= LOCKED;
                                    r_locked <= 1'b1;
                                end
                            end
                        end else if (w_timeout) begin
                            r_timeout   <= 1'b1;
                            r_state     <= ACQUIRE;
                            r_ref_vld   <= 1'b0;
                            r_match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (edge_event_i) begin
                            r_period     <= w_period;
                            r_period_vld <= 1'b1;
                            r_ref        <= w_period;
                            if (!w_match) begin
                                r_lock_lost <= 1'b1;
                                r_match_cnt <= '0;
                                r_state     <= MEASURE;
                                r_locked    <= 1'b0;
                            end
                        end else if (w_timeout) begin
                            r_timeout   <= 1'b1;
                            r_lock_lost <= 1'b1;
                            r_state     <= ACQUIRE;
                            r_ref_vld   <= 1'b0;
                            r_match_cnt <= '0;
                            r_locked    <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
